// File: rtl/mul_arbiter.sv
// Two-requester front end for a single shared multiplier. Round-robin
// arbitration, one operation in flight, a four-phase handshake toward the
// multiplier, and a sticky timeout if the multiplier never completes.
module mul_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    output logic [1:0]           grant,
    output logic [1:0]           resp_done,
    output logic [2*WIDTH-1:0]   resp_prod,
    input  logic [1:0]           resp_ack,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic                 mul_valid,
    output logic                 mul_ack,
    input  logic [2*WIDTH-1:0]   mul_prod,
    input  logic                 mul_done,
    input  logic                 mul_ret_ack,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK, RESP} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [2*WIDTH-1:0]   result;
    logic [2*WIDTH-1:0]   result_d;
    logic                 idx;
    logic                 last_served;
    logic [7:0]           cnt;

    logic                 grant_idx;
    logic                 do_grant;
    logic                 load_result;
    logic                 set_timeout;
    logic                 cnt_inc;
    logic                 cnt_clr;
    logic                 serve_done;

    // The multiplier only ever sees the captured operands, so they hold
    // steady for the whole operation regardless of what requesters do.
    assign mul_a = op_a;
    assign mul_b = op_b;

    // State register; an asserted reset aborts any operation immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; every output is a function of the
    // current state so reset forces them all inactive without a clock.
    always_comb begin
        state_next  = state;
        grant       = 2'b00;
        grant_idx   = 1'b0;
        do_grant    = 1'b0;
        load_result = 1'b0;
        result_d    = '0;
        set_timeout = 1'b0;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;
        serve_done  = 1'b0;
        mul_valid   = 1'b0;
        mul_ack     = 1'b0;
        resp_done   = 2'b00;
        resp_prod   = '0;
        case (state)
            IDLE: begin
                // Gating with reset keeps grant low while reset is held.
                if (reset && (req_valid != 2'b00)) begin
                    do_grant   = 1'b1;
                    // On a tie the requester not served last wins.
                    if (req_valid == 2'b11) begin
                        grant_idx = ~last_served;
                    end else begin
                        grant_idx = req_valid[1];
                    end
                    grant      = grant_idx ? 2'b10 : 2'b01;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mul_valid = 1'b1;
                cnt_inc   = 1'b1;
                // A completion in the final allowed cycle still counts.
                if (mul_done) begin
                    load_result = 1'b1;
                    result_d    = mul_prod;
                    state_next  = ACK;
                end else if ((cnt + 8'd1) == TIMEOUT_CNT) begin
                    set_timeout = 1'b1;
                    load_result = 1'b1;
                    result_d    = '0;
                    state_next  = RESP;
                end
            end
            ACK: begin
                mul_ack = 1'b1;
                if (mul_ret_ack) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_done = idx ? 2'b10 : 2'b01;
                resp_prod = result;
                // Only the served requester's acknowledge releases us.
                if (resp_ack[idx]) begin
                    serve_done = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture and requester bookkeeping at grant / completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a        <= '0;
            op_b        <= '0;
            idx         <= 1'b0;
            last_served <= 1'b1;
        end else begin
            if (do_grant) begin
                op_a <= grant_idx ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
                op_b <= grant_idx ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
                idx  <= grant_idx;
            end
            if (serve_done) begin
                last_served <= idx;
            end
        end
    end

    // Result register, ISSUE-cycle counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result      <= '0;
            cnt         <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            if (load_result) begin
                result <= result_d;
            end
            if (cnt_clr) begin
                cnt <= 8'd0;
            end else if (cnt_inc) begin
                cnt <= cnt + 8'd1;
            end
            if (set_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter. The bench plays both requesters and the
// shared multiplier; inputs change and outputs are checked just after the
// rising edge.
module tb_mul_arbiter;

    localparam int W = 32;

    logic            clk;
    logic            reset;
    logic [1:0]      req_valid;
    logic [2*W-1:0]  req_a;
    logic [2*W-1:0]  req_b;
    logic [1:0]      grant;
    logic [1:0]      resp_done;
    logic [2*W-1:0]  resp_prod;
    logic [1:0]      resp_ack;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic            mul_valid;
    logic            mul_ack;
    logic [2*W-1:0]  mul_prod;
    logic            mul_done;
    logic            mul_ret_ack;
    logic            timeout_err;

    int vectors;
    int miscompares;

    mul_arbiter #(.WIDTH(W), .TIMEOUT(255)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .grant       (grant),
        .resp_done   (resp_done),
        .resp_prod   (resp_prod),
        .resp_ack    (resp_ack),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_valid   (mul_valid),
        .mul_ack     (mul_ack),
        .mul_prod    (mul_prod),
        .mul_done    (mul_done),
        .mul_ret_ack (mul_ret_ack),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        req_valid   = 2'b00;
        resp_ack    = 2'b00;
        mul_done    = 1'b0;
        mul_ret_ack = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Acts as the multiplier: called in the first ISSUE cycle, completes
    // after 'delay' extra cycles and acknowledges one cycle later.
    task automatic mul_respond(input int delay);
        repeat (delay) tick();
        mul_done = 1'b1;
        mul_prod = 64'(mul_a) * 64'(mul_b);
        tick();
        mul_done    = 1'b0;
        mul_ret_ack = 1'b1;
        tick();
        mul_ret_ack = 1'b0;
        #1;
    endtask

    task automatic finish_resp(input logic [1:0] who);
        resp_ack = who;
        tick();
        resp_ack = 2'b00;
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        req_valid   = 2'b11;
        req_a       = {32'd1, 32'd2};
        req_b       = {32'd3, 32'd4};
        resp_ack    = 2'b00;
        mul_prod    = '0;
        mul_done    = 1'b0;
        mul_ret_ack = 1'b0;
        #1;
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rst_grant: got %b want 00", grant); end
        vectors++; if (resp_done !== 2'b00) begin miscompares++; $display("FAIL rst_resp_done: got %b want 00", resp_done); end
        vectors++; if (mul_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mul_valid: got %b want 0", mul_valid); end
        vectors++; if (mul_ack !== 1'b0) begin miscompares++; $display("FAIL rst_mul_ack: got %b want 0", mul_ack); end
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
        vectors++; if (resp_prod !== 64'd0) begin miscompares++; $display("FAIL rst_resp_prod: got %h want 0", resp_prod); end
        vectors++; if ({mul_a, mul_b} !== 64'd0) begin miscompares++; $display("FAIL rst_operands: got %h %h want 0 0", mul_a, mul_b); end
        tick();
        tick();
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rst_grant_clocked: got %b want 00", grant); end
        req_valid = 2'b00;
        reset     = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        req_valid = 2'b01;
        req_a     = {32'd99, 32'd10};
        req_b     = {32'd98, 32'd10};
        #1;
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL basic_grant: got %b want 01", grant); end
        tick();
        req_valid = 2'b00;
        #1;
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL basic_grant_pulse: got %b want 00", grant); end
        vectors++; if (mul_valid !== 1'b1) begin miscompares++; $display("FAIL basic_mul_valid: got %b want 1", mul_valid); end
        vectors++; if (mul_a !== 32'd10 || mul_b !== 32'd10) begin miscompares++; $display("FAIL basic_operands: got %0d %0d want 10 10", mul_a, mul_b); end
        tick();
        tick();
        vectors++; if (mul_valid !== 1'b1 || resp_done !== 2'b00) begin miscompares++; $display("FAIL basic_wait: got valid=%b done=%b want 1 00", mul_valid, resp_done); end
        mul_done = 1'b1;
        mul_prod = 64'(mul_a) * 64'(mul_b);
        tick();
        mul_done = 1'b0;
        #1;
        vectors++; if (mul_valid !== 1'b0 || mul_ack !== 1'b1) begin miscompares++; $display("FAIL basic_ack_phase: got valid=%b ack=%b want 0 1", mul_valid, mul_ack); end
        tick();
        vectors++; if (mul_ack !== 1'b1 || resp_done !== 2'b00) begin miscompares++; $display("FAIL basic_ack_hold: got ack=%b done=%b want 1 00", mul_ack, resp_done); end
        mul_ret_ack = 1'b1;
        tick();
        mul_ret_ack = 1'b0;
        #1;
        vectors++; if (mul_ack !== 1'b0) begin miscompares++; $display("FAIL basic_ack_drop: got %b want 0", mul_ack); end
        vectors++; if (resp_done !== 2'b01) begin miscompares++; $display("FAIL basic_resp_done: got %b want 01", resp_done); end
        vectors++; if (resp_prod !== 64'd100) begin miscompares++; $display("FAIL basic_resp_prod: got %0d want 100", resp_prod); end
        resp_ack = 2'b10;
        tick();
        resp_ack = 2'b00;
        #1;
        vectors++; if (resp_done !== 2'b01) begin miscompares++; $display("FAIL basic_wrong_ack: got %b want 01", resp_done); end
        finish_resp(2'b01);
        vectors++; if (resp_done !== 2'b00 || resp_prod !== 64'd0) begin miscompares++; $display("FAIL basic_release: got done=%b prod=%h want 00 0", resp_done, resp_prod); end
    endtask

    task automatic test_tie();
        do_reset();
        req_valid = 2'b11;
        req_a     = {32'd3, 32'd19347};
        req_b     = {32'd7, 32'd0};
        #1;
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL tie_first_grant: got %b want 01", grant); end
        tick();
        req_valid = 2'b10;
        #1;
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL tie_no_grant_busy: got %b want 00", grant); end
        mul_respond(1);
        vectors++; if (resp_done !== 2'b01 || resp_prod !== 64'd0) begin miscompares++; $display("FAIL tie_first_resp: got done=%b prod=%0d want 01 0", resp_done, resp_prod); end
        finish_resp(2'b01);
        vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL tie_second_grant: got %b want 10", grant); end
        tick();
        req_valid = 2'b00;
        mul_respond(0);
        vectors++; if (resp_done !== 2'b10 || resp_prod !== 64'd21) begin miscompares++; $display("FAIL tie_second_resp: got done=%b prod=%0d want 10 21", resp_done, resp_prod); end
        finish_resp(2'b10);
    endtask

    task automatic test_max();
        req_valid = 2'b01;
        req_a     = {32'd0, 32'hFFFF_FFFF};
        req_b     = {32'd0, 32'hFFFF_FFFF};
        tick();
        req_valid = 2'b00;
        mul_respond(3);
        vectors++; if (resp_done !== 2'b01 || resp_prod !== 64'hFFFF_FFFE_0000_0001) begin miscompares++; $display("FAIL max_prod: got done=%b prod=%h want 01 fffffffe00000001", resp_done, resp_prod); end
        finish_resp(2'b01);
    endtask

    task automatic test_back_to_back();
        logic [1:0]     exp_g;
        logic [2*W-1:0] exp_p;
        do_reset();
        req_valid = 2'b11;
        req_a     = {32'd5, 32'd4};
        req_b     = {32'd3, 32'd2};
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
            exp_p = (k % 2 == 1) ? 64'd15 : 64'd8;
            #1;
            vectors++; if (grant !== exp_g) begin miscompares++; $display("FAIL b2b_grant[%0d]: got %b want %b", k, grant, exp_g); end
            tick();
            mul_respond(1);
            vectors++; if (resp_done !== exp_g || resp_prod !== exp_p) begin miscompares++; $display("FAIL b2b_resp[%0d]: got done=%b prod=%0d want %b %0d", k, resp_done, resp_prod, exp_g, exp_p); end
            finish_resp(exp_g);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_timeout();
        req_valid = 2'b01;
        req_a     = {32'd0, 32'd2};
        req_b     = {32'd0, 32'd3};
        tick();
        req_valid = 2'b00;
        repeat (254) tick();
        vectors++; if (mul_valid !== 1'b1 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_last_issue: got valid=%b err=%b want 1 0", mul_valid, timeout_err); end
        tick();
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_err: got %b want 1", timeout_err); end
        vectors++; if (mul_valid !== 1'b0 || mul_ack !== 1'b0) begin miscompares++; $display("FAIL to_mul_idle: got valid=%b ack=%b want 0 0", mul_valid, mul_ack); end
        vectors++; if (resp_done !== 2'b01 || resp_prod !== 64'd0) begin miscompares++; $display("FAIL to_resp: got done=%b prod=%h want 01 0", resp_done, resp_prod); end
        finish_resp(2'b01);
        req_valid = 2'b10;
        req_a     = {32'd9, 32'd0};
        req_b     = {32'd9, 32'd0};
        tick();
        req_valid = 2'b00;
        mul_respond(1);
        vectors++; if (resp_done !== 2'b10 || resp_prod !== 64'd81) begin miscompares++; $display("FAIL to_after_op: got done=%b prod=%0d want 10 81", resp_done, resp_prod); end
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
        finish_resp(2'b10);
    endtask

    task automatic test_reset_abort();
        req_valid = 2'b01;
        req_a     = {32'd0, 32'd5};
        req_b     = {32'd0, 32'd5};
        tick();
        req_valid = 2'b00;
        tick();
        vectors++; if (mul_valid !== 1'b1) begin miscompares++; $display("FAIL abort_pre: got %b want 1", mul_valid); end
        reset = 1'b0;
        #1;
        vectors++; if (mul_valid !== 1'b0) begin miscompares++; $display("FAIL abort_async_valid: got %b want 0", mul_valid); end
        vectors++; if (mul_a !== 32'd0 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL abort_async_regs: got a=%0d err=%b want 0 0", mul_a, timeout_err); end
        tick();
        reset = 1'b1;
        tick();
        tick();
        vectors++; if (resp_done !== 2'b00 || mul_ack !== 1'b0) begin miscompares++; $display("FAIL abort_no_resp: got done=%b ack=%b want 00 0", resp_done, mul_ack); end
        req_valid = 2'b10;
        req_a     = {32'd6, 32'd0};
        req_b     = {32'd7, 32'd0};
        #1;
        vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL abort_regrant: got %b want 10", grant); end
        tick();
        req_valid = 2'b00;
        mul_respond(2);
        vectors++; if (resp_done !== 2'b10 || resp_prod !== 64'd42) begin miscompares++; $display("FAIL abort_after_op: got done=%b prod=%0d want 10 42", resp_done, resp_prod); end
        finish_resp(2'b10);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_tie();
        test_max();
        test_back_to_back();
        test_timeout();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand width; product width is 2*WIDTH.
REQ-002 Parameter TIMEOUT, default 255, maximum ISSUE-state cycles waiting for mul_done (8-bit counter).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester request; bit i = requester i.
REQ-006 req_a, req_b  input  2*WIDTH each  packed operands, {req1, req0}.
REQ-007 grant  output  2  one-cycle pulse; operands of requester i sampled this cycle.
REQ-008 resp_done  output  2  bit i high while resp_prod holds requester i's result.
REQ-009 resp_prod  output  2*WIDTH  result for the requester flagged in resp_done.
REQ-010 resp_ack  input  2  requester i accepts its result.
REQ-011 mul_a, mul_b  output  WIDTH each  operands to the shared multiplier.
REQ-012 mul_valid  output  1  operands valid, to multiplier valid_data.
REQ-013 mul_ack  output  1  result consumed, to multiplier ack.
REQ-014 mul_prod  input  2*WIDTH  multiplier product.
REQ-015 mul_done  input  1  multiplier Done_Flag.
REQ-016 mul_ret_ack  input  1  multiplier acknowledge of mul_ack.
REQ-017 timeout_err  output  1  sticky error flag.

Function
REQ-018 FSM states: IDLE, ISSUE, ACK, RESP; exactly one state active.
REQ-019 IDLE: with one req_valid bit set, grant that requester; with both set, grant the requester not served last (round-robin); with none, stay in IDLE.
REQ-020 On grant, latch the chosen req_a/req_b slice into operand registers, pulse grant[i] for one cycle, record index i, and go to ISSUE on the next edge.
REQ-021 mul_a/mul_b SHALL be driven only from the operand registers and SHALL stay stable from ISSUE entry to RESP exit.
REQ-022 ISSUE: mul_valid=1; the timeout counter increments each cycle; on mul_done=1, latch mul_prod into the result register and go to ACK.
REQ-023 ACK: mul_valid=0, mul_ack=1; on mul_ret_ack=1, go to RESP; mul_ack drops on that transition.
REQ-024 RESP: resp_done[i]=1, resp_prod=result register; on resp_ack[i]=1, go to IDLE, set last-served to i, clear the counter.
REQ-025 resp_ack on the non-served bit SHALL be ignored; resp_prod SHALL be 0 whenever resp_done is 0.
REQ-026 Timeout: when the counter reaches TIMEOUT in ISSUE without mul_done, set timeout_err, load 0 into the result register, drop mul_valid, and go directly to RESP (no ACK).
REQ-027 timeout_err SHALL remain set until reset.
REQ-028 Minimum latency from grant to resp_done: 2 cycles plus the multiplier compute time plus the mul_ret_ack delay.
REQ-029 Requesters SHALL deassert req_valid after grant; a bit still high on return to IDLE is a new request.
REQ-030 Product width SHALL be 2*WIDTH, no truncation; result register passed unmodified.
REQ-031 Only one operation SHALL be in flight; requests arriving outside IDLE wait, with no loss and no grant.

Reset
REQ-032 While reset=0, asynchronously: state=IDLE; grant, resp_done, mul_valid, mul_ack, timeout_err=0; resp_prod, mul_a, mul_b, operand and result registers=0; counter=0; last-served=1 (requester 0 wins first tie).
REQ-033 Reset asserted in any state aborts the operation; mul_valid drops without waiting for a clock; no resp_done is issued for the aborted request.

Verification
REQ-034 req_valid=01, a0=10, b0=10 -> grant=01 pulse, mul_a=10, mul_b=10, mul_valid high until mul_done, then resp_done=01 with resp_prod=100.
REQ-035 After reset, req_valid=11 in the same cycle, a0=19347 b0=0, a1=3 b1=7 -> requester 0 served first (resp_prod=0), then requester 1 (resp_prod=21).
REQ-036 a0=b0=4294967295 -> resp_prod=64'hFFFFFFFE00000001.
REQ-037 Both req_valid held high for 4 operations -> grants in order 01,10,01,10.
REQ-038 mul_done held 0 -> after 255 ISSUE cycles timeout_err=1, mul_valid=0, resp_done=01 with resp_prod=0; timeout_err stays 1 through later normal operations.
REQ-039 reset pulsed low during ISSUE -> mul_valid=0 immediately, no resp_done; after release, req_valid=10, a1=6, b1=7 -> resp_prod=42.
